// File: rtl/priority_sequencer.sv
// Iterative priority server: latches a request vector and hands out the 1-based
// index of each set bit, one per accepted handshake, highest- or lowest-first.
module priority_sequencer #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         load,
  input  logic         lsb_first,
  input  logic         idx_ready,
  output logic         busy,
  output logic         idx_valid,
  output logic [W-1:0] idx,
  output logic         last,
  output logic [W-1:0] count,
  output logic         done
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t       state_q, state_d;
  logic [N:1]   pend_q, pend_d;
  logic         mode_q, mode_d;
  logic [W-1:0] count_q, count_d;
  logic         done_q, done_d;

  logic [W-1:0] sel;
  logic [N:1]   selOneHot;
  logic [W-1:0] reqCount;

  // Priority pick over the pending set; the last match in scan order wins, so
  // scanning upward finds the highest bit and scanning downward the lowest.
  always_comb begin
    sel       = '0;
    selOneHot = '0;
    if (!mode_q) begin
      for (int i = 1; i <= N; i++) begin
        if (pend_q[i]) begin
          sel          = W'(i);
          selOneHot    = '0;
          selOneHot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = N; i >= 1; i--) begin
        if (pend_q[i]) begin
          sel          = W'(i);
          selOneHot    = '0;
          selOneHot[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    reqCount = '0;
    for (int i = 0; i < N; i++) begin
      reqCount = reqCount + W'(req[i]);
    end
  end

  assign busy      = (state_q == SERVE);
  assign idx_valid = busy;
  assign idx       = busy ? sel : '0;
  assign last      = busy && (count_q == W'(1));
  assign count     = count_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    count_d = count_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          pend_d  = req;
          mode_d  = lsb_first;
          count_d = reqCount;
          if (req != '0) state_d = SERVE;
          else           done_d  = 1'b1;
        end
      end
      SERVE: begin
        if (idx_ready) begin
          pend_d  = pend_q & ~selOneHot;
          count_d = count_q - W'(1);
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

endmodule
